// File: rtl/blit_pkg.sv
// Shared types for the rectangle-fill blitter: address width, FSM states, latched command.
package blit_pkg;

  localparam int BLIT_ADDR_W = 26;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ROW,
    DONE
  } blit_state_t;

  typedef struct packed {
    logic [BLIT_ADDR_W-1:0] addr;
    logic [15:0]            width;
    logic [15:0]            height;
    logic [15:0]            stride;
    logic [7:0]             color;
  } blit_fill_cmd_t;

endpackage

// File: rtl/blit_edge_mask.sv
// Byte enables for one 32-bit word of a row: clips bytes before the row start and after the row end.
module blit_edge_mask (
  input  logic [1:0] start_off_i,
  input  logic [1:0] end_off_i,
  input  logic       is_first_i,
  input  logic       is_last_i,
  output logic [3:0] byte_en_o
);

  logic [3:0] first_mask;
  logic [3:0] last_mask;

  assign first_mask = 4'b1111 << start_off_i;
  assign last_mask  = 4'b1111 >> (2'd3 - end_off_i);

  always_comb begin
    byte_en_o = 4'b1111;
    if (is_first_i) byte_en_o = byte_en_o & first_mask;
    if (is_last_i)  byte_en_o = byte_en_o & last_mask;
  end

endmodule

// File: rtl/blit_rect_fill.sv
// Rectangle fill: one word write per cycle along each row, first write 2 cycles after accept,
// one SETUP bubble between rows; fifo_full stalls the row without losing or repeating words.
module blit_rect_fill
  import blit_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [BLIT_ADDR_W-1:0] cmd_addr,
  input  logic [15:0]            cmd_width,
  input  logic [15:0]            cmd_height,
  input  logic [15:0]            cmd_stride,
  input  logic [7:0]             cmd_color,
  output logic                   out_write,
  output logic [BLIT_ADDR_W-1:0] out_addr,
  output logic [31:0]            out_data,
  output logic [3:0]             out_byte_enable,
  input  logic                   fifo_full,
  output logic                   done
);

  blit_state_t            state_q;
  blit_fill_cmd_t         cmd_d;
  logic [BLIT_ADDR_W-1:0] row_addr_q;
  logic [15:0]            width_q;
  logic [15:0]            stride_q;
  logic [7:0]             color_q;
  logic [15:0]            rows_left_q;
  logic [BLIT_ADDR_W-3:0] cur_word_q;
  logic [BLIT_ADDR_W-3:0] last_word_q;
  logic [BLIT_ADDR_W-1:0] end_addr_d;
  logic                   is_first_d;
  logic                   is_last_d;
  logic [3:0]             byte_en_d;

  assign cmd_d = '{addr: cmd_addr, width: cmd_width, height: cmd_height,
                   stride: cmd_stride, color: cmd_color};

  assign cmd_ready  = (state_q == IDLE);
  // Address of the last byte of the current row; the natural 26-bit wrap is intended.
  assign end_addr_d = row_addr_q + BLIT_ADDR_W'(width_q) - BLIT_ADDR_W'(1);
  assign is_first_d = (cur_word_q == row_addr_q[BLIT_ADDR_W-1:2]);
  assign is_last_d  = (cur_word_q == last_word_q);

  blit_edge_mask u_edge_mask (
    .start_off_i (row_addr_q[1:0]),
    .end_off_i   (end_addr_d[1:0]),
    .is_first_i  (is_first_d),
    .is_last_i   (is_last_d),
    .byte_en_o   (byte_en_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      out_write       <= 1'b0;
      done            <= 1'b0;
      out_addr        <= '0;
      out_data        <= '0;
      out_byte_enable <= '0;
      row_addr_q      <= '0;
      width_q         <= '0;
      stride_q        <= '0;
      color_q         <= '0;
      rows_left_q     <= '0;
      cur_word_q      <= '0;
      last_word_q     <= '0;
    end else begin
      out_write <= 1'b0;
      done      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            row_addr_q  <= cmd_d.addr;
            width_q     <= cmd_d.width;
            stride_q    <= cmd_d.stride;
            color_q     <= cmd_d.color;
            rows_left_q <= cmd_d.height;
            if (cmd_d.width == 16'd0 || cmd_d.height == 16'd0) state_q <= DONE;
            else                                                state_q <= SETUP;
          end
        end
        SETUP: begin
          cur_word_q  <= row_addr_q[BLIT_ADDR_W-1:2];
          last_word_q <= end_addr_d[BLIT_ADDR_W-1:2];
          state_q     <= ROW;
        end
        ROW: begin
          if (!fifo_full) begin
            out_write       <= 1'b1;
            out_addr        <= {cur_word_q, 2'b00};
            out_data        <= {4{color_q}};
            out_byte_enable <= byte_en_d;
            if (is_last_d) begin
              row_addr_q  <= row_addr_q + BLIT_ADDR_W'(stride_q);
              rows_left_q <= rows_left_q - 16'd1;
              state_q     <= (rows_left_q == 16'd1) ? DONE : SETUP;
            end else begin
              cur_word_q <= cur_word_q + 1'b1;
            end
          end
        end
        DONE: begin
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
